// File: rtl/fixed_point_pkg.sv
// Shared types and width helpers for the sequential fixed-point divider.
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int qw_f(input int dec, input int frac);
    return dec + frac;
  endfunction

  localparam int DEC_DEF  = 10;
  localparam int FRAC_DEF = 8;
  localparam int QW_DEF   = qw_f(DEC_DEF, FRAC_DEF);

  localparam logic [QW_DEF-1:0] SAT_DEF = '1;

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract if it fits.
module fixed_point_div_step #(
  parameter int DEC = 10
) (
  input  logic [DEC-1:0] rem_i,
  input  logic           dbit_i,
  input  logic [DEC-1:0] div_i,
  output logic [DEC-1:0] rem_o,
  output logic           qbit_o
);

  logic [DEC:0] rsh;

  always_comb begin
    rsh    = {rem_i, dbit_i};
    qbit_o = (rsh >= {1'b0, div_i});
    // The difference is below div_i, so the low DEC bits hold it exactly.
    rem_o  = qbit_o ? (rsh[DEC-1:0] - div_i) : rsh[DEC-1:0];
  end

endmodule

// File: rtl/fixed_point_div_seq.sv
// Sequential restoring divider: n_out = floor((n1 << FRAC) / n2), one bit per clock.
// FIXED_POINT_DIV_ROUND_EN adds a guard iteration and rounds half up.
module fixed_point_div_seq
  import fixed_point_pkg::*;
#(
  parameter int DEC  = 10,
  parameter int FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DEC-1:0]          n1,
  input  logic [DEC-1:0]          n2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [qw_f(DEC,FRAC)-1:0] n_out,
  output logic [DEC-1:0]          rem_out,
  output logic                    div_zero
);

  localparam int QW = qw_f(DEC, FRAC);
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam int ITER = QW + 1;
`else
  localparam int ITER = QW;
`endif
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [QW-1:0] SAT      = '1;

  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [DEC-1:0] n1_q, n1_d;
  logic [DEC-1:0] n2_q, n2_d;
  logic [DEC-1:0] rem_q, rem_d;
  logic [QW-1:0]  dvd_q, dvd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [QW-1:0]  n_out_q, n_out_d;
  logic [DEC-1:0] rem_out_q, rem_out_d;
  logic           dz_q, dz_d;

  logic [DEC-1:0] rem_nxt;
  logic           qbit;
  logic           dbit;

  // Dividend bits leave at the top while quotient bits enter at the bottom.
`ifdef FIXED_POINT_DIV_ROUND_EN
  assign dbit = (cnt_q == '0) ? 1'b0 : dvd_q[QW-1];
`else
  assign dbit = dvd_q[QW-1];
`endif

  fixed_point_div_step #(
    .DEC (DEC)
  ) u_step (
    .rem_i  (rem_q),
    .dbit_i (dbit),
    .div_i  (n2_q),
    .rem_o  (rem_nxt),
    .qbit_o (qbit)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    n_out_d   = n_out_q;
    rem_out_d = rem_out_q;
    dz_d      = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          n1_d    = n1;
          n2_d    = n2;
          start_d = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (start_q) begin
          start_d = 1'b0;
          if (n2_q == '0) begin
            state_d   = DONE;
            n_out_d   = SAT;
            rem_out_d = '0;
            dz_d      = 1'b1;
          end else begin
            rem_d = '0;
            dvd_d = {n1_q, {FRAC{1'b0}}};
            cnt_d = CNT_INIT;
          end
        end
`ifdef FIXED_POINT_DIV_ROUND_EN
        else if (cnt_q == '0) begin
          state_d   = DONE;
          dz_d      = 1'b0;
          rem_out_d = rem_q;
          n_out_d   = (dvd_q == SAT) ? SAT :
                      dvd_q + {{(QW-1){1'b0}}, qbit};
        end
`endif
        else begin
          rem_d = rem_nxt;
          dvd_d = {dvd_q[QW-2:0], qbit};
          if (cnt_q == '0) begin
            state_d   = DONE;
            dz_d      = 1'b0;
            n_out_d   = {dvd_q[QW-2:0], qbit};
            rem_out_d = rem_nxt;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      n1_q      <= '0;
      n2_q      <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      n_out_q   <= '0;
      rem_out_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      cnt_q     <= cnt_d;
      n_out_q   <= n_out_d;
      rem_out_q <= rem_out_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign n_out     = n_out_q;
  assign rem_out   = rem_out_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_fixed_point_div_seq.sv
// Directed and randomised bench for fixed_point_div_seq (DEC=10, FRAC=8).
module tb_fixed_point_div_seq;

  localparam int DEC  = 10;
  localparam int FRAC = 8;
  localparam int QW   = DEC + FRAC;
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam int LAT  = QW + 2;
  localparam int Q353 = 245;
  localparam bit RND  = 1'b1;
`else
  localparam int LAT  = QW + 1;
  localparam int Q353 = 244;
  localparam bit RND  = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DEC-1:0] n1;
  logic [DEC-1:0] n2;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] n_out;
  logic [DEC-1:0] rem_out;
  logic          div_zero;

  int checks;
  int failures;

  fixed_point_div_seq #(
    .DEC  (DEC),
    .FRAC (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n1        (n1),
    .n2        (n2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_out     (n_out),
    .rem_out   (rem_out),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake one operand pair and wait (bounded) for the result.
  task automatic run_op(input logic [DEC-1:0] a, input logic [DEC-1:0] b,
                        output int lat, output logic [QW-1:0] q,
                        output logic [DEC-1:0] r, output logic dz,
                        output bit rdy_low);
    in_valid = 1'b1;
    n1 = a;
    n2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n1 = DEC'($urandom);
    n2 = DEC'($urandom);
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) rdy_low = 1'b0;
    end
    if (!out_valid) lat = 999;
    q  = n_out;
    r  = rem_out;
    dz = div_zero;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n1 = '0;
    n2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (n_out !== '0) begin
      failures++; $display("FAIL reset_n_out got=%0d exp=0", n_out);
    end
    checks++;
    if (rem_out !== '0) begin
      failures++; $display("FAIL reset_rem_out got=%0d exp=0", rem_out);
    end
    checks++;
    if (div_zero !== 1'b0) begin
      failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int ta[3] = '{1, 1, 353};
    int tb[3] = '{1, 2, 369};
    int tq[3] = '{256, 128, Q353};
    int tr[3] = '{0, 0, 332};
    int lat;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    for (int i = 0; i < 3; i++) begin
      run_op(DEC'(ta[i]), DEC'(tb[i]), lat, q, r, dz, rl);
      checks++;
      if (lat !== LAT) begin
        failures++; $display("FAIL basic%0d_latency got=%0d exp=%0d", i, lat, LAT);
      end
      checks++;
      if (q !== QW'(tq[i])) begin
        failures++; $display("FAIL basic%0d_n_out got=%0d exp=%0d", i, q, tq[i]);
      end
      checks++;
      if (r !== DEC'(tr[i])) begin
        failures++; $display("FAIL basic%0d_rem got=%0d exp=%0d", i, r, tr[i]);
      end
      checks++;
      if (dz !== 1'b0 || rl !== 1'b1) begin
        failures++; $display("FAIL basic%0d_dz_rdy got=%b/%b exp=0/1", i, dz, rl);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic%0d_release got=%b/%b exp=1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    run_op(DEC'(7), DEC'(0), lat, q, r, dz, rl);
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL dz_latency got=%0d exp=1", lat);
    end
    checks++;
    if (q !== 18'h3FFFF || r !== '0 || dz !== 1'b1) begin
      failures++;
      $display("FAIL dz_result got=%h/%0d/%b exp=3ffff/0/1", q, r, dz);
    end
    release_out();
    run_op(DEC'(0), DEC'(5), lat, q, r, dz, rl);
    checks++;
    if (lat !== LAT || q !== '0 || r !== '0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL dz_next got=%0d/%0d/%0d/%b exp=%0d/0/0/0", lat, q, r, dz, LAT);
    end
    release_out();
  endtask

  task automatic test_corner();
    int ta[3] = '{1023, 1023, 3};
    int tb[3] = '{1, 1023, 4};
    int tq[3] = '{261888, 256, 192};
    int lat;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    for (int i = 0; i < 3; i++) begin
      run_op(DEC'(ta[i]), DEC'(tb[i]), lat, q, r, dz, rl);
      checks++;
      if (lat !== LAT || q !== QW'(tq[i]) || r !== '0 || dz !== 1'b0) begin
        failures++;
        $display("FAIL corner%0d got=%0d/%0d/%0d/%b exp=%0d/%0d/0/0",
                 i, lat, q, r, dz, LAT, tq[i]);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    // 256000 / 3 = 85333 rem 1; guard bit is 0 so rounding leaves it.
    run_op(DEC'(1000), DEC'(3), lat, q, r, dz, rl);
    checks++;
    if (lat !== LAT || q !== QW'(85333) || r !== DEC'(1)) begin
      failures++;
      $display("FAIL bp_result got=%0d/%0d/%0d exp=%0d/85333/1", lat, q, r, LAT);
    end
    in_valid = 1'b1;
    n1 = DEC'(5);
    n2 = DEC'(1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          n_out !== QW'(85333) || rem_out !== DEC'(1)) begin
        failures++;
        $display("FAIL bp_hold%0d got=%b/%b/%0d/%0d exp=1/0/85333/1",
                 i, out_valid, in_ready, n_out, rem_out);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_stray_op got=%b/%b exp=1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    in_valid = 1'b1;
    n1 = DEC'(100);
    n2 = DEC'(7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_out !== '0) begin
      failures++;
      $display("FAIL midrst_state got=%b/%b/%0d exp=1/0/0", in_ready, out_valid, n_out);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL midrst_stale got=%b exp=0", seen);
    end
    run_op(DEC'(3), DEC'(4), lat, q, r, dz, rl);
    checks++;
    if (lat !== LAT || q !== QW'(192) || r !== '0) begin
      failures++;
      $display("FAIL midrst_next got=%0d/%0d/%0d exp=%0d/192/0", lat, q, r, LAT);
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    logic [QW-1:0] q;
    logic [DEC-1:0] r;
    logic dz;
    bit rl;
    int a, b, eq, er, elat;
    bit edz;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 1023));
      b = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(1, 1023));
      if (b == 0) begin
        eq = (1 << QW) - 1; er = 0; edz = 1'b1; elat = 1;
      end else begin
        eq = (a << FRAC) / b;
        er = (a << FRAC) % b;
        edz = 1'b0;
        elat = LAT;
        if (RND && (2 * er >= b) && eq != (1 << QW) - 1) eq = eq + 1;
      end
      run_op(DEC'(a), DEC'(b), lat, q, r, dz, rl);
      checks++;
      if (lat !== elat || q !== QW'(eq) || r !== DEC'(er) || dz !== edz) begin
        failures++;
        $display("FAIL rand%0d %0d/%0d got=%0d/%0d/%0d/%b exp=%0d/%0d/%0d/%b",
                 i, a, b, lat, q, r, dz, elat, eq, er, edz);
      end
      release_out();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_corner();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
